mem_arbiter: RTL

//  Shares one single-port 32-bit memory between three requesters: the CPU load/fetch port
//  (m_in_*), the CPU store port (m_out_*) and an external DMA/debug port (dma_*). Converts
//  CPU byte/half/word accesses into word-aligned memory cycles with byte enables. Sits

---
 rtl/mem_arb_pkg.sv | 52 +++++
 rtl/mem_lane_align.sv | 27 ++
 rtl/mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and lane helpers for the memory arbiter.
// Offsets that a size cannot use (a[0] for halves, a[1:0] for words) are forced to zero here.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESPOND
    } state_e;

    typedef enum logic [1:0] {
        OWN_RD,
        OWN_WR,
        OWN_DMA
    } owner_e;

    function automatic logic [1:0] eff_offset(size_e sz, logic [1:0] a);
        case (sz)
            SZ_HALF: return {a[1], 1'b0};
            SZ_WORD: return 2'b00;
            default: return a;
        endcase
    endfunction

    function automatic logic [3:0] size_to_be(size_e sz, logic [1:0] a);
        case (sz)
            SZ_BYTE: return 4'b0001 << eff_offset(sz, a);
            SZ_HALF: return 4'b0011 << eff_offset(sz, a);
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(logic [31:0] rdata, size_e sz, logic [1:0] a);
        logic [31:0] sh;
        sh = rdata >> {eff_offset(sz, a), 3'b000};
        case (sz)
            SZ_BYTE: return {24'h0, sh[7:0]};
            SZ_HALF: return {16'h0, sh[15:0]};
            SZ_WORD: return sh;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated write data for the granted
// access, and right-aligned, zero-filled extraction of read data for the access in flight.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  wr_size_i,
    input  logic [1:0]  wr_off_i,
    input  logic [31:0] wr_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [1:0]  rd_size_i,
    input  logic [1:0]  rd_off_i,
    input  logic [31:0] rd_data_i,
    output logic [31:0] rd_data_o
);

    always_comb begin
        be_o = size_to_be(size_e'(wr_size_i), wr_off_i);
        case (size_e'(wr_size_i))
            SZ_BYTE: wdata_o = {4{wr_data_i[7:0]}};
            SZ_HALF: wdata_o = {2{wr_data_i[15:0]}};
            default: wdata_o = wr_data_i;
        endcase
        rd_data_o = lane_extract(rd_data_i, size_e'(rd_size_i), rd_off_i);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way arbiter (CPU write > CPU read > DMA, with DMA anti-starvation) in front of one
// single-port memory. Define MEM_ARB_ALIGN_CHECK_EN to reject misaligned CPU accesses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  m_in_sig_read,
    input  logic [31:0] m_in_addr,
    output logic [31:0] m_in_data,
    output logic        m_in_ready,
    input  logic [1:0]  m_out_sig_write,
    input  logic [31:0] m_out_addr,
    input  logic [31:0] m_out_data,
    output logic        m_out_ready,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    logic        rd_pend_q, wr_pend_q, mis_rd_q, mis_wr_q, err_q;
    size_e       rd_size_q, wr_size_q;
    logic [31:0] rd_addr_q, wr_addr_q, wr_data_q;

    state_e      state_q;
    owner_e      owner_q;
    size_e       cur_size_q;
    logic [1:0]  cur_off_q;
    logic [7:0]  starve_q;
    logic        mem_req_q, mem_we_q, m_in_ready_q, m_out_ready_q, dma_done_q;
    logic [31:0] mem_addr_q, mem_wdata_q, m_in_data_q, dma_rdata_q;
    logic [3:0]  mem_be_q;

    logic        rd_stb, wr_stb, rd_mis, wr_mis, ack_fire, dma_first, any_req;
    owner_e      sel_own;
    size_e       sel_size;
    logic [1:0]  sel_off;
    logic [31:0] sel_addr, sel_data, sel_wdata, ext_rdata;
    logic        sel_we;
    logic [3:0]  sel_be;

    assign rd_stb = (m_in_sig_read != 2'd0);
    assign wr_stb = (m_out_sig_write != 2'd0);

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign rd_mis = (m_in_sig_read == 2'd2 && m_in_addr[0]) ||
                    (m_in_sig_read == 2'd3 && m_in_addr[1:0] != 2'b00);
    assign wr_mis = (m_out_sig_write == 2'd2 && m_out_addr[0]) ||
                    (m_out_sig_write == 2'd3 && m_out_addr[1:0] != 2'b00);
`else
    assign rd_mis = 1'b0;
    assign wr_mis = 1'b0;
`endif

    assign ack_fire = (state_q == ST_ISSUE) && mem_ack;

    // Strobes are accepted in any FSM state; a strobe on a port that is still busy is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            mis_rd_q  <= 1'b0;
            mis_wr_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_size_q <= SZ_NONE;
            wr_size_q <= SZ_NONE;
            rd_addr_q <= 32'h0;
            wr_addr_q <= 32'h0;
            wr_data_q <= 32'h0;
        end else begin
            mis_rd_q <= 1'b0;
            mis_wr_q <= 1'b0;
            if (ack_fire && owner_q == OWN_RD) rd_pend_q <= 1'b0;
            if (ack_fire && owner_q == OWN_WR) wr_pend_q <= 1'b0;
            if (rd_stb) begin
                if (rd_pend_q || mis_rd_q) begin
                    err_q <= 1'b1;
                end else if (rd_mis) begin
                    err_q    <= 1'b1;
                    mis_rd_q <= 1'b1;
                end else begin
                    rd_pend_q <= 1'b1;
                    rd_size_q <= size_e'(m_in_sig_read);
                    rd_addr_q <= m_in_addr;
                end
            end
            if (wr_stb) begin
                if (wr_pend_q || mis_wr_q) begin
                    err_q <= 1'b1;
                end else if (wr_mis) begin
                    err_q    <= 1'b1;
                    mis_wr_q <= 1'b1;
                end else begin
                    wr_pend_q <= 1'b1;
                    wr_size_q <= size_e'(m_out_sig_write);
                    wr_addr_q <= m_out_addr;
                    wr_data_q <= m_out_data;
                end
            end
        end
    end

    assign dma_first = dma_req && ((starve_q == STARVE_LIMIT[7:0]) || (!wr_pend_q && !rd_pend_q));
    assign any_req   = wr_pend_q || rd_pend_q || dma_req;

    always_comb begin
        sel_own  = OWN_DMA;
        sel_size = SZ_WORD;
        sel_off  = 2'b00;
        sel_addr = dma_addr & 32'hFFFF_FFFC;
        sel_data = dma_wdata;
        sel_we   = dma_we;
        if (!dma_first && wr_pend_q) begin
            sel_own  = OWN_WR;
            sel_size = wr_size_q;
            sel_off  = wr_addr_q[1:0];
            sel_addr = wr_addr_q & 32'hFFFF_FFFC;
            sel_data = wr_data_q;
            sel_we   = 1'b1;
        end else if (!dma_first && rd_pend_q) begin
            sel_own  = OWN_RD;
            sel_size = rd_size_q;
            sel_off  = rd_addr_q[1:0];
            sel_addr = rd_addr_q & 32'hFFFF_FFFC;
            sel_data = 32'h0;
            sel_we   = 1'b0;
        end
    end

    mem_lane_align u_align (
        .wr_size_i (sel_size),
        .wr_off_i  (sel_off),
        .wr_data_i (sel_data),
        .be_o      (sel_be),
        .wdata_o   (sel_wdata),
        .rd_size_i (cur_size_q),
        .rd_off_i  (cur_off_q),
        .rd_data_i (mem_rdata),
        .rd_data_o (ext_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_RD;
            cur_size_q    <= SZ_NONE;
            cur_off_q     <= 2'b00;
            starve_q      <= 8'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_be_q      <= 4'h0;
            mem_wdata_q   <= 32'h0;
            m_in_data_q   <= 32'h0;
            dma_rdata_q   <= 32'h0;
            m_in_ready_q  <= 1'b0;
            m_out_ready_q <= 1'b0;
            dma_done_q    <= 1'b0;
        end else begin
            m_in_ready_q  <= 1'b0;
            m_out_ready_q <= 1'b0;
            dma_done_q    <= 1'b0;
            if (!dma_req) starve_q <= 8'd0;
            // Rejected misaligned accesses complete without touching memory.
            if (mis_rd_q) begin
                m_in_ready_q <= 1'b1;
                m_in_data_q  <= 32'h0;
            end
            if (mis_wr_q) m_out_ready_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_be_q    <= sel_be;
                        mem_wdata_q <= sel_wdata;
                        owner_q     <= sel_own;
                        cur_size_q  <= sel_size;
                        cur_off_q   <= sel_off;
                        if (sel_own == OWN_DMA) starve_q <= 8'd0;
                        else if (dma_req && starve_q != 8'hFF) starve_q <= starve_q + 8'd1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        case (owner_q)
                            OWN_RD: begin
                                m_in_ready_q <= 1'b1;
                                m_in_data_q  <= ext_rdata;
                            end
                            OWN_WR: m_out_ready_q <= 1'b1;
                            default: begin
                                dma_done_q <= 1'b1;
                                if (!mem_we_q) dma_rdata_q <= mem_rdata;
                            end
                        endcase
                        state_q <= ST_RESPOND;
                    end
                end
                ST_RESPOND: state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_in_data   = m_in_data_q;
    assign m_in_ready  = m_in_ready_q;
    assign m_out_ready = m_out_ready_q;
    assign dma_rdata   = dma_rdata_q;
    assign dma_done    = dma_done_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign err         = err_q;

endmodule
